// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the two-port multiplier arbiter: FSM state encoding
// and default operand width / watchdog limit.
package mult_arbiter_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester and multiplier-side signals of the arbiter; the arbiter sits on the
// slave modport, the requesters/multiplier environment on the master modport.
interface mult_arbiter_if
  import mult_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic                 req0;
  logic                 req1;
  logic [WIDTH-1:0]     a0;
  logic [WIDTH-1:0]     b0;
  logic [WIDTH-1:0]     a1;
  logic [WIDTH-1:0]     b1;
  logic                 ack0;
  logic                 ack1;
  logic [2*WIDTH-1:0]   result;
  logic                 err;
  logic                 busy;
  logic                 grant_id;
  logic                 mult_start;
  logic [WIDTH-1:0]     mult_a;
  logic [WIDTH-1:0]     mult_b;
  logic                 mult_done;
  logic [2*WIDTH-1:0]   mult_result;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, mult_done, mult_result,
    output ack0, ack1, result, err, busy, grant_id, mult_start, mult_a, mult_b
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, mult_done, mult_result,
    input  ack0, ack1, result, err, busy, grant_id, mult_start, mult_a, mult_b
  );
endinterface

// File: rtl/mult_arbiter_timeout_counter.sv
// Watchdog counter for the WAIT state: clears on clr_i, counts on en_i and
// flags the last allowed wait cycle (count == TIMEOUT-1) on tc_o.
module arb_timeout_counter
  import mult_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end for the shared sequential multiplier: grants one of two
// requesters, pulses start, waits for done under a watchdog, then acks the winner.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  mult_arbiter_if.slave bus
);
  arb_state_e         state_q;
  logic               last_q;
  logic               grant_q;
  logic               ack0_q;
  logic               ack1_q;
  logic               err_q;
  logic               busy_q;
  logic               start_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] result_q;
  logic               tc;
  logic               cnt_clr;
  logic               cnt_en;
  logic               pick1;

  // Port 1 wins when alone, or when both ask and port 0 was served last.
  assign pick1   = bus.req1 && (!bus.req0 || !last_q);
  assign cnt_clr = (state_q == ARB_ISSUE);
  assign cnt_en  = (state_q == ARB_WAIT) && !bus.mult_done && !tc;

  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      last_q   <= 1'b1;
      grant_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      start_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (bus.req0 || bus.req1) begin
            grant_q <= pick1;
            a_q     <= pick1 ? bus.a1 : bus.a0;
            b_q     <= pick1 ? bus.b1 : bus.b0;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          state_q <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // A real completion on the final watchdog cycle still counts as success.
          if (bus.mult_done) begin
            result_q <= bus.mult_result;
            err_q    <= 1'b0;
            ack0_q   <= !grant_q;
            ack1_q   <= grant_q;
            state_q  <= ARB_RESP;
          end else if (tc) begin
            result_q <= '0;
            err_q    <= 1'b1;
            ack0_q   <= !grant_q;
            ack1_q   <= grant_q;
            state_q  <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          last_q  <= grant_q;
          busy_q  <= 1'b0;
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.result     = result_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = grant_q;
  assign bus.mult_start = start_q;
  assign bus.mult_a     = a_q;
  assign bus.mult_b     = b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: a delay-programmable multiplier model plus a
// scoreboard of expected (port, product, err) entries checked on every ack.
module tb_mult_arbiter;
  import mult_arbiter_pkg::*;

  localparam int W  = DEFAULT_WIDTH;
  localparam int TO = 64;

  typedef struct {
    logic         port;
    logic [2*W-1:0] res;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mult_arbiter_if #(.WIDTH(W)) bus ();

  mult_arbiter #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Multiplier model: done arrives model_delay cycles after the start cycle;
  // model_delay == 0 means it never answers.
  int             model_delay = 0;
  int             model_cnt   = 0;
  logic           model_armed = 1'b0;
  logic           model_done  = 1'b0;
  logic [2*W-1:0] model_prod  = '0;
  logic           inject_done = 1'b0;
  logic [2*W-1:0] inject_res  = '0;

  assign bus.mult_done   = model_done | inject_done;
  assign bus.mult_result = model_done ? model_prod : inject_res;

  always @(negedge clk) begin
    model_done <= 1'b0;
    if (model_armed) begin
      if (model_cnt <= 1) begin
        model_done  <= 1'b1;
        model_armed <= 1'b0;
      end else begin
        model_cnt <= model_cnt - 1;
      end
    end
    if (bus.mult_start && model_delay > 0) begin
      model_armed <= 1'b1;
      model_cnt   <= model_delay;
      model_prod  <= {{W{1'b0}}, bus.mult_a} * {{W{1'b0}}, bus.mult_b};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input int res, input logic err);
    exp_t e;
    e.port = port;
    e.res  = (2*W)'(res);
    e.err  = err;
    sb.push_back(e);
  endtask

  // Waits for the next ack (bounded), scores it and drops the served request.
  task automatic wait_ack(input string tag, input int limit, output int lat,
                          output int start_at, output int starts);
    bit   got;
    exp_t e;
    got      = 1'b0;
    lat      = 0;
    start_at = -1;
    starts   = 0;
    for (int n = 1; n <= limit && !got; n++) begin
      @(negedge clk);
      if (bus.mult_start) begin
        starts++;
        if (start_at < 0) start_at = n;
      end
      if (bus.ack0 || bus.ack1) begin
        got = 1'b1;
        lat = n;
        chk({tag, "_one_ack"}, {31'b0, bus.ack0 & bus.ack1}, 0);
        chk({tag, "_busy_at_ack"}, {31'b0, bus.busy}, 1);
        chk({tag, "_sb_nonempty"}, {31'b0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk({tag, "_port"}, {31'b0, bus.ack1}, {31'b0, e.port});
          chk({tag, "_grant_id"}, {31'b0, bus.grant_id}, {31'b0, e.port});
          chk({tag, "_result"}, {16'b0, bus.result}, {16'b0, e.res});
          chk({tag, "_err"}, {31'b0, bus.err}, {31'b0, e.err});
        end
        $display("txn %s: port=%0d result=%0d err=%0d latency=%0d", tag, bus.ack1, bus.result, bus.err, n);
        if (bus.ack1) bus.req1 = 1'b0;
        else          bus.req0 = 1'b0;
      end
    end
    chk({tag, "_ack_seen"}, {31'b0, got}, 1);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      chk({tag, "_no_ack"}, {31'b0, bus.ack0 | bus.ack1}, 0);
      chk({tag, "_not_busy"}, {31'b0, bus.busy}, 0);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ack0"}, {31'b0, bus.ack0}, 0);
    chk({tag, "_ack1"}, {31'b0, bus.ack1}, 0);
    chk({tag, "_start"}, {31'b0, bus.mult_start}, 0);
    chk({tag, "_mult_a"}, {24'b0, bus.mult_a}, 0);
    chk({tag, "_mult_b"}, {24'b0, bus.mult_b}, 0);
    chk({tag, "_result"}, {16'b0, bus.result}, 0);
    chk({tag, "_err"}, {31'b0, bus.err}, 0);
    chk({tag, "_busy"}, {31'b0, bus.busy}, 0);
    chk({tag, "_grant_id"}, {31'b0, bus.grant_id}, 0);
  endtask

  initial begin
    int lat, sat, nst;
    bit seen;
    reset    = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0   = '0;
    bus.b0   = '0;
    bus.a1   = '0;
    bus.b1   = '0;
    repeat (2) @(negedge clk);
    all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Simultaneous requests from reset, then keep both busy to see alternation.
    model_delay = 1;
    bus.a0 = 8'd3; bus.b0 = 8'd4; bus.a1 = 8'd5; bus.b1 = 8'd6;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    push(1'b0, 12, 1'b0); push(1'b1, 30, 1'b0);
    wait_ack("sim0", 20, lat, sat, nst);
    chk("sim0_latency", lat, 3);
    @(negedge clk); bus.req0 = 1'b1; push(1'b0, 12, 1'b0);
    wait_ack("sim1", 20, lat, sat, nst);
    chk("sim1_back_to_back", lat, 3);
    @(negedge clk); bus.req1 = 1'b1; push(1'b1, 30, 1'b0);
    wait_ack("alt2", 20, lat, sat, nst);
    @(negedge clk); bus.req0 = 1'b1; push(1'b0, 12, 1'b0);
    wait_ack("alt3", 20, lat, sat, nst);
    wait_ack("alt4", 20, lat, sat, nst);
    idle_check("after_alt", 2);

    // Single request with an 8-cycle multiplier.
    model_delay = 8;
    bus.a0 = 8'd12; bus.b0 = 8'd13; bus.req0 = 1'b1;
    push(1'b0, 156, 1'b0);
    wait_ack("single", 40, lat, sat, nst);
    chk("single_latency", lat, 10);
    chk("single_start_cycle", sat, 1);
    chk("single_start_count", nst, 1);
    chk("single_mult_a", {24'b0, bus.mult_a}, 12);
    chk("single_mult_b", {24'b0, bus.mult_b}, 13);

    // Watchdog expiry, then a stale done while idle.
    @(negedge clk);
    model_delay = 0;
    bus.a1 = 8'd9; bus.b1 = 8'd9; bus.req1 = 1'b1;
    push(1'b1, 0, 1'b1);
    wait_ack("timeout", 100, lat, sat, nst);
    chk("timeout_latency", lat, TO + 2);
    repeat (4) @(negedge clk);
    inject_res  = 16'hBEEF;
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    idle_check("late_done", 3);
    chk("late_done_result_held", {16'b0, bus.result}, 0);
    chk("late_done_err_held", {31'b0, bus.err}, 1);
    model_delay = 3;
    bus.a0 = 8'd2; bus.b0 = 8'd3; bus.req0 = 1'b1;
    push(1'b0, 6, 1'b0);
    wait_ack("after_timeout", 20, lat, sat, nst);
    chk("after_timeout_latency", lat, 5);

    // Operands change while waiting; latched values must be used.
    @(negedge clk);
    model_delay = 6;
    bus.a0 = 8'd7; bus.b0 = 8'd11; bus.req0 = 1'b1;
    push(1'b0, 77, 1'b0);
    repeat (3) @(negedge clk);
    bus.a0 = 8'd9;
    wait_ack("stable", 20, lat, sat, nst);
    chk("stable_mult_a", {24'b0, bus.mult_a}, 7);

    // Reset in the middle of WAIT abandons the operation.
    @(negedge clk);
    model_delay = 20;
    bus.a0 = 8'd10; bus.b0 = 8'd10; bus.req0 = 1'b1;
    repeat (5) @(negedge clk);
    reset    = 1'b1;
    bus.req0 = 1'b0;
    #1;
    all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      #1;
      chk("postreset_no_ack", {31'b0, bus.ack0 | bus.ack1}, 0);
      chk("postreset_not_busy", {31'b0, bus.busy}, 0);
      if (bus.mult_done) seen = 1'b1;
    end
    chk("postreset_stale_done_seen", {31'b0, seen}, 1);
    idle_check("stale_done", 1);
    chk("stale_done_result", {16'b0, bus.result}, 0);
    model_delay = 4;
    bus.a0 = 8'd255; bus.b0 = 8'd255; bus.req0 = 1'b1;
    push(1'b0, 65025, 1'b0);
    wait_ack("max_operands", 20, lat, sat, nst);
    chk("max_operands_latency", lat, 6);

    // Done arrives on the last watchdog cycle: success wins.
    @(negedge clk);
    model_delay = TO;
    bus.a1 = 8'd200; bus.b1 = 8'd3; bus.req1 = 1'b1;
    push(1'b1, 600, 1'b0);
    wait_ack("done_at_limit", 100, lat, sat, nst);
    chk("done_at_limit_latency", lat, TO + 2);

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
